// File: rtl/axi_sram_mem.sv
// AXI4 slave in front of a single-port word SRAM: AW/AR/B queues, one W-or-R array
// access per cycle under round-robin arbitration, registered R output.
package axi_sram_pkg;
  localparam int unsigned AxiAddrW = 32;
  localparam int unsigned AxiDataW = 64;
  localparam int unsigned AxiIdW   = 4;
  localparam int unsigned AxiUserW = 1;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic [5:0]          atop;
    logic [AxiUserW-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [AxiDataW-1:0]   data;
    logic [AxiDataW/8-1:0] strb;
    logic                  last;
    logic [AxiUserW-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic [AxiUserW-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [1:0]          resp;
    logic [AxiUserW-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiDataW-1:0] data;
    logic [1:0]          resp;
    logic                last;
    logic [AxiUserW-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } rsp_t;
endpackage

module axi_sram_fifo #(
  parameter type         T     = logic,
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic empty,
  output logic full
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  T                store [Depth];
  logic [PtrW-1:0] wptr, rptr;
  logic [PtrW:0]   cnt;

  assign empty = (cnt == '0);
  assign full  = (cnt == (PtrW+1)'(Depth));
  assign dout  = store[rptr];

  always_ff @(posedge clk_i)
    if (push) store[wptr] <= din;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= (wptr == PtrW'(Depth-1)) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == PtrW'(Depth-1)) ? '0 : rptr + 1'b1;
      cnt <= cnt + (PtrW+1)'(push) - (PtrW+1)'(pop);
    end
  end
endmodule

module axi_sram_mem
  import axi_sram_pkg::*;
#(
  parameter int unsigned           AddrWidth = 32,
  parameter int unsigned           DataWidth = 64,
  parameter int unsigned           IdWidth   = 4,
  parameter int unsigned           UserWidth = 1,
  parameter type                   req_t     = axi_sram_pkg::req_t,
  parameter type                   rsp_t     = axi_sram_pkg::rsp_t,
  parameter int unsigned           NumWords  = 1024,
  parameter logic [AddrWidth-1:0]  BaseAddr  = '0,
  parameter int unsigned           MaxTxn    = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  req_t axi_req_i,
  output rsp_t axi_rsp_o
);
  localparam int unsigned StrbW = DataWidth / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(NumWords);
  localparam logic [1:0]  Okay  = 2'b00;
  localparam logic [1:0]  SlvErr = 2'b10;

  function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] a,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [AddrWidth-1:0] step, al, wmask;
    step  = AddrWidth'(1) << size;
    al    = a & ~(step - 1'b1);
    wmask = ((AddrWidth'(len) + 1'b1) << size) - 1'b1;
    case (burst)
      2'b00:   return a;
      2'b10:   return (al & ~wmask) | ((al + step) & wmask);
      default: return al + step;
    endcase
  endfunction

  aw_chan_t aw_head;
  ar_chan_t ar_head;
  b_chan_t  b_in, b_head;
  logic aw_empty, aw_full, ar_empty, ar_full, b_empty, b_full;

  logic [DataWidth-1:0] mem [NumWords];
  logic [DataWidth-1:0] rdata_q;
  logic [7:0]           w_cnt_q, r_cnt_q;
  logic [AddrWidth-1:0] w_addr_q, r_addr_q, w_baddr, r_baddr;
  logic [AddrWidth:0]   w_diff, r_diff;
  logic [IdxW-1:0]      w_idx, r_idx;
  logic w_err_q, prio_w_q, r_valid_q, r_last_q;
  logic [IdWidth-1:0]   r_id_q;
  logic [1:0]           r_resp_q;
  logic w_last, r_last, w_req, r_req, w_gnt, r_gnt, w_beat, w_oob, r_oob, w_atop;

  assign w_last  = (w_cnt_q == aw_head.len);
  assign r_last  = (r_cnt_q == ar_head.len);
  assign w_atop  = (aw_head.atop != '0);
  assign w_baddr = (w_cnt_q == '0) ? aw_head.addr : w_addr_q;
  assign r_baddr = (r_cnt_q == '0) ? ar_head.addr : r_addr_q;

  // The borrow bit of the offset flags addresses below the base.
  assign w_diff = {1'b0, w_baddr} - {1'b0, BaseAddr};
  assign r_diff = {1'b0, r_baddr} - {1'b0, BaseAddr};
  assign w_oob  = w_diff[AddrWidth] | (|w_diff[AddrWidth-1:OffW+IdxW]);
  assign r_oob  = r_diff[AddrWidth] | (|r_diff[AddrWidth-1:OffW+IdxW]);
  assign w_idx  = w_diff[OffW +: IdxW];
  assign r_idx  = r_diff[OffW +: IdxW];

  assign w_req  = ~aw_empty & (~w_last | ~b_full);
  assign r_req  = ~ar_empty & (~r_valid_q | axi_req_i.r_ready);
  assign w_gnt  = w_req & (~r_req | prio_w_q);
  assign r_gnt  = r_req & ~w_gnt;
  assign w_beat = w_gnt & axi_req_i.w_valid;

  always_comb begin
    b_in      = '0;
    b_in.id   = aw_head.id;
    b_in.resp = (w_err_q | w_oob | w_atop) ? SlvErr : Okay;
  end

  axi_sram_fifo #(.T(aw_chan_t), .Depth(MaxTxn)) u_aw_fifo (
    .clk_i, .rst_ni, .push(axi_req_i.aw_valid & axi_rsp_o.aw_ready), .din(axi_req_i.aw),
    .pop(w_beat & w_last), .dout(aw_head), .empty(aw_empty), .full(aw_full));

  axi_sram_fifo #(.T(ar_chan_t), .Depth(MaxTxn)) u_ar_fifo (
    .clk_i, .rst_ni, .push(axi_req_i.ar_valid & axi_rsp_o.ar_ready), .din(axi_req_i.ar),
    .pop(r_gnt & r_last), .dout(ar_head), .empty(ar_empty), .full(ar_full));

  axi_sram_fifo #(.T(b_chan_t), .Depth(MaxTxn)) u_b_fifo (
    .clk_i, .rst_ni, .push(w_beat & w_last), .din(b_in),
    .pop(~b_empty & axi_req_i.b_ready), .dout(b_head), .empty(b_empty), .full(b_full));

  always_ff @(posedge clk_i) begin
    if (w_beat && !w_oob && !w_atop)
      for (int b = 0; b < StrbW; b++)
        if (axi_req_i.w.strb[b]) mem[w_idx][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
    if (r_gnt) rdata_q <= r_oob ? '0 : mem[r_idx];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_cnt_q   <= '0;
      w_addr_q  <= '0;
      w_err_q   <= 1'b0;
      r_cnt_q   <= '0;
      r_addr_q  <= '0;
      prio_w_q  <= 1'b1;
      r_valid_q <= 1'b0;
      r_id_q    <= '0;
      r_resp_q  <= '0;
      r_last_q  <= 1'b0;
    end else begin
      // Priority only moves when both sides actually contend.
      if (w_req && r_req) prio_w_q <= ~prio_w_q;
      if (w_beat) begin
        if (w_last) begin
          w_cnt_q <= '0;
          w_err_q <= 1'b0;
        end else begin
          w_cnt_q  <= w_cnt_q + 8'd1;
          w_err_q  <= w_err_q | w_oob;
          w_addr_q <= next_addr(w_baddr, aw_head.len, aw_head.size, aw_head.burst);
        end
      end
      if (r_gnt) begin
        r_valid_q <= 1'b1;
        r_id_q    <= ar_head.id;
        r_resp_q  <= r_oob ? SlvErr : Okay;
        r_last_q  <= r_last;
        if (r_last) r_cnt_q <= '0;
        else begin
          r_cnt_q  <= r_cnt_q + 8'd1;
          r_addr_q <= next_addr(r_baddr, ar_head.len, ar_head.size, ar_head.burst);
        end
      end else if (axi_req_i.r_ready) begin
        r_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = rst_ni & ~aw_full;
    axi_rsp_o.ar_ready = rst_ni & ~ar_full;
    axi_rsp_o.w_ready  = w_gnt;
    axi_rsp_o.b_valid  = ~b_empty;
    axi_rsp_o.b        = b_head;
    axi_rsp_o.r_valid  = r_valid_q;
    axi_rsp_o.r.id     = r_id_q;
    axi_rsp_o.r.data   = rdata_q;
    axi_rsp_o.r.resp   = r_resp_q;
    axi_rsp_o.r.last   = r_last_q;
    axi_rsp_o.r.user   = UserWidth'(0);
  end

  logic unused;
  assign unused = ^{axi_req_i.w.last, axi_req_i.w.user, aw_head.user, ar_head.user, w_diff, r_diff};
endmodule

// File: tb/tb_axi_sram_mem.sv
// Randomized + directed bench for axi_sram_mem against a byte-level memory model.
module tb_axi_sram_mem;
  import axi_sram_pkg::*;
  localparam int NW = 1024;
  localparam int MT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  req_t req;
  rsp_t rsp;

  always #5 clk = ~clk;

  axi_sram_mem #(.NumWords(NW), .MaxTxn(MT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .axi_req_i(req), .axi_rsp_o(rsp));

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference memory: word data plus a per-byte "written since reset" mask.
  logic [63:0] mdat [NW];
  logic [7:0]  mknw [NW];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  logic [63:0] rd [256];
  logic [1:0]  rr [256];
  logic        rl [256];
  logic [3:0]  rid [256];

  function automatic logic [31:0] baddr(logic [31:0] a, int len, int size, int burst, int i);
    int unsigned st, wsz;
    logic [31:0] al, lo;
    st = 1 << size;
    al = a - a % st;
    if (i == 0 || burst == 0) return a;
    if (burst == 1) return al + i * st;
    wsz = (len + 1) * st;
    lo  = a - a % wsz;
    return lo + (al - lo + i * st) % wsz;
  endfunction

  function automatic bit is_oob(logic [31:0] a);
    return (a / 8) >= NW;
  endfunction

  function automatic logic [1:0] mdl_write(logic [31:0] addr, int len, int size, int burst,
                                            logic [5:0] atop);
    bit err = (atop != 0);
    for (int i = 0; i <= len; i++) begin
      logic [31:0] a = baddr(addr, len, size, burst, i);
      if (is_oob(a)) err = 1;
      else if (atop == 0)
        for (int b = 0; b < 8; b++)
          if (ws[i][b]) begin
            mdat[a/8][8*b +: 8] = wd[i][8*b +: 8];
            mknw[a/8][b] = 1'b1;
          end
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  task automatic aw_send(int id, logic [31:0] addr, int len, int size, int burst, logic [5:0] atop);
    req.aw.id = 4'(id); req.aw.addr = addr; req.aw.len = 8'(len);
    req.aw.size = 3'(size); req.aw.burst = 2'(burst); req.aw.atop = atop; req.aw.user = '0;
    req.aw_valid = 1'b1;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (rsp.aw_ready) break;
      if (c > 1000) begin chk("aw_timeout", rsp.aw_ready, 1); break; end
    end
    @(posedge clk); #1 req.aw_valid = 1'b0;
  endtask

  task automatic ar_send(int id, logic [31:0] addr, int len, int size, int burst);
    req.ar.id = 4'(id); req.ar.addr = addr; req.ar.len = 8'(len);
    req.ar.size = 3'(size); req.ar.burst = 2'(burst); req.ar.user = '0;
    req.ar_valid = 1'b1;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (rsp.ar_ready) break;
      if (c > 1000) begin chk("ar_timeout", rsp.ar_ready, 1); break; end
    end
    @(posedge clk); #1 req.ar_valid = 1'b0;
  endtask

  task automatic w_set(int i, int len);
    req.w.data = wd[i]; req.w.strb = ws[i]; req.w.last = (i == len); req.w.user = '0;
  endtask

  task automatic w_beat_hs(string tag);
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (rsp.w_ready) break;
      if (c > 1000) begin chk({tag, "_w_timeout"}, rsp.w_ready, 1); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic w_send(int len);
    for (int i = 0; i <= len; i++) begin
      w_set(i, len);
      req.w_valid = 1'b1;
      w_beat_hs("w");
    end
    req.w_valid = 1'b0;
  endtask

  task automatic b_wait(output logic [3:0] bid, output logic [1:0] bresp);
    req.b_ready = 1'b1;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (rsp.b_valid) break;
      if (c > 1000) begin chk("b_timeout", rsp.b_valid, 1); break; end
    end
    bid = rsp.b.id; bresp = rsp.b.resp;
    @(posedge clk); #1 req.b_ready = 1'b0;
  endtask

  task automatic cap_r(int k);
    rd[k] = rsp.r.data; rr[k] = rsp.r.resp; rl[k] = rsp.r.last; rid[k] = rsp.r.id;
  endtask

  task automatic r_collect(string tag, int len);
    int k = 0;
    req.r_ready = 1'b1;
    for (int c = 0; k <= len && c < 2000; c++) begin
      @(negedge clk);
      if (rsp.r_valid) begin cap_r(k); k++; end
    end
    @(posedge clk); #1 req.r_ready = 1'b0;
    if (k <= len) chk({tag, "_rcnt"}, k, len + 1);
  endtask

  task automatic rd_check(string tag, int id, logic [31:0] addr, int len, int size, int burst);
    for (int i = 0; i <= len; i++) begin
      logic [31:0] a = baddr(addr, len, size, burst, i);
      logic [63:0] m;
      if (is_oob(a)) begin
        chk($sformatf("%s_d%0d", tag, i), rd[i], 64'h0);
        chk($sformatf("%s_resp%0d", tag, i), rr[i], 2'b10);
      end else begin
        for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{mknw[a/8][b]}};
        if (m != 0) chk($sformatf("%s_d%0d", tag, i), rd[i] & m, mdat[a/8] & m);
        chk($sformatf("%s_resp%0d", tag, i), rr[i], 2'b00);
      end
      chk($sformatf("%s_last%0d", tag, i), rl[i], (i == len));
      chk($sformatf("%s_id%0d", tag, i), rid[i], id);
    end
  endtask

  task automatic do_write(string tag, int id, logic [31:0] addr, int len, int size, int burst,
                          logic [5:0] atop);
    logic [3:0] bid;
    logic [1:0] bresp, exp;
    aw_send(id, addr, len, size, burst, atop);
    w_send(len);
    b_wait(bid, bresp);
    exp = mdl_write(addr, len, size, burst, atop);
    chk({tag, "_bresp"}, bresp, exp);
    chk({tag, "_bid"}, bid, id);
  endtask

  task automatic do_read(string tag, int id, logic [31:0] addr, int len, int size, int burst);
    ar_send(id, addr, len, size, burst);
    r_collect(tag, len);
    rd_check(tag, id, addr, len, size, burst);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic [63:0] keep0;
    int k, wi, bu, sz, ln, ad;
    bit wr;

    req = '0;
    for (int i = 0; i < NW; i++) mknw[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awr", rsp.aw_ready, 0);
    chk("rst_arr", rsp.ar_ready, 0);
    chk("rst_wr",  rsp.w_ready, 0);
    chk("rst_bv",  rsp.b_valid, 0);
    chk("rst_rv",  rsp.r_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("c1_awr", rsp.aw_ready, 1);
    chk("c1_arr", rsp.ar_ready, 1);
    chk("c1_bv",  rsp.b_valid, 0);
    chk("c1_rv",  rsp.r_valid, 0);

    // Basic INCR write then read back.
    for (int i = 0; i < 4; i++) begin wd[i] = 64'hA0 + 64'(i); ws[i] = 8'hFF; end
    do_write("incr_w", 1, 32'h10, 3, 3, 1, 6'h0);
    do_read("incr_r", 1, 32'h10, 3, 3, 1);
    for (int i = 0; i < 4; i++) chk($sformatf("incr_val%0d", i), rd[i], 64'hA0 + 64'(i));

    // Contending W and R every cycle: first conflict since reset goes to write.
    for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    req.aw.id = 4'd6; req.aw.addr = 32'h100; req.aw.len = 8'd7; req.aw.size = 3'd3;
    req.aw.burst = 2'd1; req.aw.atop = '0; req.aw_valid = 1'b1;
    req.ar.id = 4'd7; req.ar.addr = 32'h10; req.ar.len = 8'd3; req.ar.size = 3'd3;
    req.ar.burst = 2'd1; req.ar_valid = 1'b1;
    @(negedge clk);
    chk("alt_awr", rsp.aw_ready, 1);
    chk("alt_arr", rsp.ar_ready, 1);
    @(posedge clk); #1;
    req.aw_valid = 1'b0; req.ar_valid = 1'b0;
    req.r_ready = 1'b1; wi = 0; k = 0;
    w_set(0, 7); req.w_valid = 1'b1;
    for (int c = 0; c < 60 && (wi <= 7 || k <= 3); c++) begin
      @(negedge clk);
      if (c < 8) chk($sformatf("alt_wgnt%0d", c), rsp.w_ready, (c % 2 == 0));
      wr = rsp.w_ready & req.w_valid;
      if (rsp.r_valid && k < 4) begin cap_r(k); k++; end
      @(posedge clk); #1;
      if (wr) begin
        wi++;
        if (wi > 7) req.w_valid = 1'b0; else w_set(wi, 7);
      end
    end
    req.r_ready = 1'b0;
    chk("alt_rcnt", k, 4);
    chk("alt_wcnt", wi, 8);
    rd_check("alt_r", 7, 32'h10, 3, 3, 1);
    b_wait(bid, bresp);
    chk("alt_bresp", bresp, mdl_write(32'h100, 7, 3, 1, 6'h0));
    chk("alt_bid", bid, 6);
    do_read("alt_rb", 2, 32'h100, 7, 3, 1);

    // Atomic write is swallowed with SLVERR and leaves memory untouched.
    for (int i = 0; i < 4; i++) begin wd[i] = 64'h55; ws[i] = 8'hFF; end
    do_write("atop_w", 3, 32'h10, 3, 3, 1, 6'h20);
    do_read("atop_r", 3, 32'h10, 3, 3, 1);

    // WRAP placement.
    for (int i = 0; i < 4; i++) begin wd[i] = 64'hB0 + 64'(i); ws[i] = 8'hFF; end
    do_write("wrap_w", 4, 32'h18, 3, 3, 2, 6'h0);
    do_read("wrap_lin", 4, 32'h0, 3, 3, 1);
    keep0 = rd[0];
    chk("wrap_a00", keep0, 64'hB1);
    chk("wrap_a18", rd[3], 64'hB0);
    do_read("wrap_r", 4, 32'h18, 3, 3, 2);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_val%0d", i), rd[i], 64'hB0 + 64'(i));

    // Burst running off the top of memory.
    wd[0] = 64'hC0; wd[1] = 64'hC1; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write("oob_w", 5, 32'h1FF8, 1, 3, 1, 6'h0);
    do_read("oob_r", 5, 32'h1FF8, 1, 3, 1);
    chk("oob_r0", rd[0], 64'hC0);
    chk("oob_r1resp", rr[1], 2'b10);

    // B backpressure: AW queue fills, then the last W beat waits for B space.
    req.b_ready = 1'b0;
    for (int j = 0; j < MT; j++) aw_send(j, 32'h200 + 32'(8*j), 0, 3, 1, 6'h0);
    @(negedge clk);
    chk("bp_aw_full", rsp.aw_ready, 0);
    @(posedge clk); #1;
    for (int j = 0; j < MT; j++) begin
      wd[0] = 64'hD0 + 64'(j); ws[0] = 8'hFF;
      w_send(0);
      void'(mdl_write(32'h200 + 32'(8*j), 0, 3, 1, 6'h0));
    end
    aw_send(MT, 32'h200 + 32'(8*MT), 0, 3, 1, 6'h0);
    wd[0] = 64'hD0 + 64'(MT); ws[0] = 8'hFF;
    w_set(0, 0); req.w_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin @(negedge clk); chk("bp_w_stall", rsp.w_ready, 0); end
    @(posedge clk); #1;
    b_wait(bid, bresp);
    chk("bp_b0_id", bid, 0);
    chk("bp_b0_resp", bresp, 0);
    w_beat_hs("bp_w5");
    req.w_valid = 1'b0;
    void'(mdl_write(32'h200 + 32'(8*MT), 0, 3, 1, 6'h0));
    for (int j = 1; j <= MT; j++) begin
      b_wait(bid, bresp);
      chk($sformatf("bp_b%0d_id", j), bid, j);
      chk($sformatf("bp_b%0d_resp", j), bresp, 0);
    end
    do_read("bp_r", 8, 32'h200, MT, 3, 1);

    // Random bursts.
    for (int t = 0; t < 40; t++) begin
      bu = $urandom_range(0, 2);
      sz = $urandom_range(0, 3);
      ln = (bu == 2) ? (2 << $urandom_range(0, 3)) - 1 : $urandom_range(0, 15);
      ad = $urandom_range(0, 32'h2080);
      if (bu == 2) ad = ad - ad % (1 << sz);
      for (int i = 0; i <= ln; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
      do_write($sformatf("rnd_w%0d", t), $urandom_range(0, 15), ad, ln, sz, bu, 6'h0);
      do_read($sformatf("rnd_r%0d", t), $urandom_range(0, 15), ad, ln, sz, bu);
    end

    // Reset in the middle of a read burst.
    ar_send(9, 32'h40, 7, 3, 1);
    req.r_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 100 && k < 2; c++) begin @(negedge clk); if (rsp.r_valid) k++; end
    @(posedge clk); #2 rst_n = 1'b0; #1;
    chk("mid_rst_rv",  rsp.r_valid, 0);
    chk("mid_rst_awr", rsp.aw_ready, 0);
    chk("mid_rst_arr", rsp.ar_ready, 0);
    chk("mid_rst_wr",  rsp.w_ready, 0);
    for (int i = 0; i < NW; i++) mknw[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin @(negedge clk); chk("post_rst_rv", rsp.r_valid, 0); end
    req.r_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin wd[i] = 64'hE0 + 64'(i); ws[i] = 8'hFF; end
    do_write("post_w", 10, 32'h40, 3, 3, 1, 6'h0);
    do_read("post_r", 10, 32'h40, 3, 3, 1);
    chk("post_val0", rd[0], 64'hE0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_sram_mem.md
AXI_SRAM_MEM -- requirements
Module: axi_sram_mem

Interface
REQ-001 AddrWidth, 32, AXI address width; nonzero.
REQ-002 DataWidth, 64, AXI data width; power of two, >= 8.
REQ-003 IdWidth, 4, AXI ID width; nonzero.
REQ-004 UserWidth, 1, AXI user width; nonzero.
REQ-005 req_t / rsp_t, logic, AXI4 request/response structs.
REQ-006 NumWords, 1024, memory depth in DataWidth words; power of two, >= 2.
REQ-007 BaseAddr, 0, byte address of word 0; aligned to NumWords*DataWidth/8.
REQ-008 MaxTxn, 4, depth of each AW, AR and B queue; >= 1.
REQ-009 clk_i  input  1  clock, rising edge.
REQ-010 rst_ni  input  1  reset, asynchronous, active-low.
REQ-011 axi_req_i  input  req_t  AXI4 request.
REQ-012 axi_rsp_o  output  rsp_t  AXI4 response.

Function
REQ-013 AW and AR FIFOs, MaxTxn deep; aw_ready = !aw_full, ar_ready = !ar_full; no bypass, so a full FIFO stays not-ready even if popped in the same cycle.
REQ-014 Single-port word array; at most one W or R beat accesses it per cycle.
REQ-015 Arbitration: a lone requester wins; when both are pending, round-robin, with write winning the first conflict after reset.
REQ-016 Write request pending: AW FIFO non-empty and, on the last beat, B FIFO not full; w_ready = granted write request.
REQ-017 Read request pending: AR FIFO non-empty and R output register empty or being drained (r_valid & r_ready) this cycle.
REQ-018 Read latency: granted in cycle N, r_valid in cycle N+1; r held stable until r_ready.
REQ-019 Beat address per AXI4: FIXED repeats addr; INCR adds 2^size per beat from the size-aligned start; WRAP wraps within the (len+1)*2^size aligned window.
REQ-020 Word index = (beat_addr - BaseAddr) >> log2(DataWidth/8), modulo-free; the beat is out-of-range (OOB) if beat_addr < BaseAddr or index >= NumWords.
REQ-021 Writes update only bytes with strb set; narrow transfers rely solely on strb.
REQ-022 Reads return the full word; r.id = ar.id; r.last is set on beat len; r.user = 0.
REQ-023 Beat counter counts to AW len and ignores w.last; burst ends on beat len.
REQ-024 OOB write beat: no array update; burst B resp = SLVERR if any beat is OOB, else OKAY.
REQ-025 OOB read beat: data 0, resp SLVERR; other beats OKAY.
REQ-026 aw.atop != 0: all W beats accepted and discarded, B = SLVERR, no R generated.
REQ-027 On last W beat, push {id, resp} into the B FIFO; b_valid = !b_empty; pop on b_valid & b_ready.
REQ-028 No AR/AW ordering: a read may return data from before or after a concurrent write, per arbitration.
REQ-029 Bursts of len 0..255 and all sizes up to log2(DataWidth/8) are supported.

Reset
REQ-030 rst_ni low asynchronously clears FIFOs, beat counters, arbiter state and the R register; aw_ready, w_ready, ar_ready, b_valid and r_valid are all 0 while rst_ni is low.
REQ-031 After deassertion, cycle 1: aw_ready = ar_ready = 1, all valids 0.
REQ-032 Array contents are not reset; reads of unwritten words return an undefined value.
REQ-033 Reset mid-burst abandons all in-flight transactions; no B or R responses are produced for them.

Verification
REQ-034 Write INCR addr 0x10, len 3, size 3, data 0xA0..0xA3, full strb -> B OKAY; then read same -> 4 beats 0xA0..0xA3, last on beat 4.
REQ-035 WRAP addr 0x18, len 3, size 3 -> beat addresses 0x18, 0x00, 0x08, 0x10 for both write and read.
REQ-036 INCR write starting at the last word, len 1 -> word updated, second beat dropped, B SLVERR; read of same range -> beat 1 OKAY, beat 2 data 0 SLVERR.
REQ-037 MaxTxn+1 AWs with b_ready = 0 -> aw_ready low after MaxTxn; W stalls on the last beat of burst MaxTxn+1 until one B is popped.
REQ-038 Simultaneous W and R requests every cycle -> grants alternate W, R, W, R.
REQ-039 rst_ni low mid read burst -> r_valid 0 immediately; after reset no stale R beat; new read succeeds.
